// File: rtl/kbe_multi.sv
// kbe_multi: N-key synchroniser + debounce FSM with a single-event reader port.
// In: clk, rst, key_raw, data_ack. Out: key_stable, press/release_pulse, data_available, key_code, overrun, inhibit.
module kbe_multi #(
  parameter int N_KEYS      = 4,
  parameter int DEB_CYCLES  = 54000,
  parameter int SYNC_STAGES = 2,
  parameter int CODE_W      = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_raw,
  input  logic              data_ack,
  output logic [N_KEYS-1:0] key_stable,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic              data_available,
  output logic [CODE_W-1:0] key_code,
  output logic              overrun,
  output logic              inhibit
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    D_PRESS = 2'd1,
    PRESSED = 2'd2,
    D_REL   = 2'd3
  } st_e;

  logic [N_KEYS-1:0] sync_q [SYNC_STAGES];
  logic [N_KEYS-1:0] key_sync;

  st_e              state_q [N_KEYS];
  st_e              state_d [N_KEYS];
  logic [CNT_W-1:0] cnt_q   [N_KEYS];
  logic [CNT_W-1:0] cnt_d   [N_KEYS];

  logic [N_KEYS-1:0] prs;
  logic [N_KEYS-1:0] rls;
  logic [N_KEYS-1:0] stable_d;

  logic [N_KEYS-1:0] stable_q;
  logic [N_KEYS-1:0] press_q;
  logic [N_KEYS-1:0] rel_q;
  logic              da_q, da_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              ov_q, ov_d;
  logic              inh_q;

  logic [CODE_W-1:0] low;
  logic              multi;
  logic              ack_eff;

  // Synchroniser chain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= key_raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign key_sync = sync_q[SYNC_STAGES-1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      stable_q <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      da_q     <= 1'b0;
      code_q   <= '0;
      ov_q     <= 1'b0;
      inh_q    <= 1'b0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      stable_q <= stable_d;
      press_q  <= prs;
      rel_q    <= rls;
      da_q     <= da_d;
      code_q   <= code_d;
      ov_q     <= ov_d;
      inh_q    <= |stable_d;
    end
  end

  // Next-state logic, one debounce FSM per key
  always_comb begin
    prs = '0;
    rls = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (key_sync[i]) begin
            state_d[i] = D_PRESS;
            cnt_d[i]   = '0;
          end
        end
        D_PRESS: begin
          if (!key_sync[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = PRESSED;
            prs[i]     = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        PRESSED: begin
          if (!key_sync[i]) begin
            state_d[i] = D_REL;
            cnt_d[i]   = '0;
          end
        end
        D_REL: begin
          if (key_sync[i]) begin
            state_d[i] = PRESSED;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = IDLE;
            rls[i]     = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      endcase
    end
  end

  // Output logic: stable levels and event capture
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      stable_d[i] = (state_d[i] == PRESSED) || (state_d[i] == D_REL);
    end

    low = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (prs[i]) low = CODE_W'(i);
    end
    // More than one bit set: clearing the lowest leaves something
    multi = |(prs & (prs - N_KEYS'(1)));

    ack_eff = data_ack & da_q;
    da_d    = da_q;
    code_d  = code_q;
    ov_d    = ov_q;
    if (|prs) begin
      if (!da_q || ack_eff) begin
        da_d   = 1'b1;
        code_d = low;
        ov_d   = multi;
      end else begin
        ov_d = 1'b1;
      end
    end else if (ack_eff) begin
      da_d = 1'b0;
      ov_d = 1'b0;
    end
  end

  assign key_stable     = stable_q;
  assign press_pulse    = press_q;
  assign release_pulse  = rel_q;
  assign data_available = da_q;
  assign key_code       = code_q;
  assign overrun        = ov_q;
  assign inhibit        = inh_q;

endmodule

// File: tb/tb_kbe_multi.sv
// tb_kbe_multi: directed plan steps then random key traffic, checked
// against a run-length debounce model with a delayed-sample queue.
module tb_kbe_multi;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int SYN = 2;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  key_raw = '0;
  logic          data_ack = 1'b0;
  logic [N-1:0]  key_stable;
  logic [N-1:0]  press_pulse;
  logic [N-1:0]  release_pulse;
  logic          data_available;
  logic [CW-1:0] key_code;
  logic          overrun;
  logic          inhibit;

  int n_chk  = 0;
  int n_fail = 0;

  kbe_multi #(
    .N_KEYS(N),
    .DEB_CYCLES(DEB),
    .SYNC_STAGES(SYN),
    .CODE_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_raw(key_raw),
    .data_ack(data_ack),
    .key_stable(key_stable),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .data_available(data_available),
    .key_code(key_code),
    .overrun(overrun),
    .inhibit(inhibit)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [N-1:0] mq[$];
  int           run[N];
  logic [N-1:0] m_stable = '0;
  logic [N-1:0] e_press  = '0;
  logic [N-1:0] e_rel    = '0;
  logic         e_da     = 1'b0;
  logic [CW-1:0] e_code  = '0;
  logic         e_ov     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int s = 0; s < SYN; s++) mq.push_back('0);
    for (int k = 0; k < N; k++) run[k] = 0;
    m_stable = '0;
    e_press  = '0;
    e_rel    = '0;
    e_da     = 1'b0;
    e_code   = '0;
    e_ov     = 1'b0;
  endtask

  // A level change is accepted once the synchronised input has
  // disagreed with the accepted level for DEB+1 consecutive edges.
  task automatic model_edge();
    logic [N-1:0] s;
    logic [N-1:0] p;
    logic [N-1:0] r;
    logic         ack_eff;
    int           lowest;
    if (rst) begin
      model_reset();
      return;
    end
    s = mq[0];
    mq.push_back(key_raw);
    void'(mq.pop_front());
    p = '0;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (s[k] != m_stable[k]) run[k]++;
      else run[k] = 0;
      if (run[k] == DEB + 1) begin
        m_stable[k] = ~m_stable[k];
        run[k] = 0;
        if (m_stable[k]) p[k] = 1'b1;
        else r[k] = 1'b1;
      end
    end
    ack_eff = data_ack && e_da;
    lowest = 0;
    for (int k = 0; k < N; k++) begin
      if (p[k]) begin
        lowest = k;
        break;
      end
    end
    if (p != 0) begin
      if (!e_da || ack_eff) begin
        e_da   = 1'b1;
        e_code = CW'(lowest);
        e_ov   = ($countones(p) > 1);
      end else begin
        e_ov = 1'b1;
      end
    end else if (ack_eff) begin
      e_da = 1'b0;
      e_ov = 1'b0;
    end
    e_press = p;
    e_rel   = r;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("key_stable", 32'(key_stable), 32'(m_stable));
    chk("press_pulse", 32'(press_pulse), 32'(e_press));
    chk("release_pulse", 32'(release_pulse), 32'(e_rel));
    chk("data_available", 32'(data_available), 32'(e_da));
    chk("key_code", 32'(key_code), 32'(e_code));
    chk("overrun", 32'(overrun), 32'(e_ov));
    chk("inhibit", 32'(inhibit), 32'(|m_stable));
  endtask

  task automatic tick_n(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  initial begin
    model_reset();

    // Reset and clean press of key 2
    rst = 1'b1;
    tick_n(3);
    chk("rst_outputs", 32'({key_stable, press_pulse, data_available, inhibit}), 32'h0);
    rst = 1'b0;
    key_raw = 4'b0100;
    tick_n(6);
    chk("press_early", 32'(press_pulse), 32'h0);
    tick();
    chk("press_k2", 32'(press_pulse), 32'h4);
    chk("stable_k2", 32'(key_stable), 32'h4);
    chk("inhibit_k2", 32'(inhibit), 32'h1);
    chk("da_k2", 32'(data_available), 32'h1);
    chk("code_k2", 32'(key_code), 32'h2);
    chk("ov_k2", 32'(overrun), 32'h0);
    tick();
    chk("press_one_cycle", 32'(press_pulse), 32'h0);
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    chk("ack_clears_da", 32'(data_available), 32'h0);
    key_raw = 4'b0000;
    tick_n(10);

    // Bounce on key 1
    key_raw = 4'b0010; tick_n(2);
    key_raw = 4'b0000; tick_n(2);
    key_raw = 4'b0010; tick_n(2);
    key_raw = 4'b0000; tick_n(20);
    chk("bounce_da", 32'(data_available), 32'h0);
    chk("bounce_stable", 32'(key_stable), 32'h0);

    // Release glitch on key 0
    key_raw = 4'b0001; tick_n(10);
    data_ack = 1'b1; tick();
    data_ack = 1'b0;
    key_raw = 4'b0000; tick_n(2);
    key_raw = 4'b0001; tick_n(10);
    chk("glitch_stable", 32'(key_stable), 32'h1);
    key_raw = 4'b0000; tick_n(6);
    chk("rel_early", 32'(release_pulse), 32'h0);
    tick();
    chk("rel_k0", 32'(release_pulse), 32'h1);
    chk("rel_stable", 32'(key_stable), 32'h0);
    chk("rel_da", 32'(data_available), 32'h0);
    tick_n(4);

    // Overrun: key 3 then key 1 without ack
    key_raw = 4'b1000; tick_n(10);
    key_raw = 4'b1010; tick_n(10);
    chk("ovr_da", 32'(data_available), 32'h1);
    chk("ovr_code", 32'(key_code), 32'h3);
    chk("ovr_flag", 32'(overrun), 32'h1);
    data_ack = 1'b1; tick();
    data_ack = 1'b0;
    chk("ovr_ack_da", 32'(data_available), 32'h0);
    chk("ovr_ack_ov", 32'(overrun), 32'h0);
    key_raw = 4'b0000; tick_n(10);

    // Simultaneous presses, then ack on a completing press
    key_raw = 4'b1010; tick_n(7);
    chk("sim_press", 32'(press_pulse), 32'ha);
    chk("sim_code", 32'(key_code), 32'h1);
    chk("sim_ov", 32'(overrun), 32'h1);
    tick_n(3);
    key_raw = 4'b1110; tick_n(6);
    data_ack = 1'b1; tick();
    data_ack = 1'b0;
    chk("ackpress_da", 32'(data_available), 32'h1);
    chk("ackpress_code", 32'(key_code), 32'h2);
    chk("ackpress_ov", 32'(overrun), 32'h0);
    key_raw = 4'b0000; tick_n(10);

    // Reset mid-debounce
    key_raw = 4'b0001; tick_n(6);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("midrst_press", 32'(press_pulse), 32'h0);
    tick_n(6);
    chk("midrst_early", 32'(press_pulse), 32'h0);
    tick();
    chk("midrst_press_k0", 32'(press_pulse), 32'h1);
    key_raw = 4'b0000; tick_n(10);

    // Random traffic
    for (int t = 0; t < 3000; t++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(11) == 0) key_raw[k] = ~key_raw[k];
      end
      data_ack = ($urandom_range(3) == 0);
      rst = ($urandom_range(399) == 0);
      tick();
    end
    rst = 1'b0;
    data_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
